// File: rtl/gate_vector_checker_if.sv
// Bus bundle between a controller and the gate vector checker.
// Optional build macro GATE_CHK_LOG_EN adds the first-failure log signals.
interface gate_vector_checker_if;
    logic       start;
    logic       a_o;
    logic       b_o;
    logic [6:0] gates_i;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [1:0] vec_idx;
`ifdef GATE_CHK_LOG_EN
    logic [1:0] first_fail_vec;
    logic [6:0] first_fail_mask;

    modport master (
        output start, gates_i,
        input  a_o, b_o, busy, done, pass, err_count, vec_idx,
               first_fail_vec, first_fail_mask
    );
    modport slave (
        input  start, gates_i,
        output a_o, b_o, busy, done, pass, err_count, vec_idx,
               first_fail_vec, first_fail_mask
    );
`else
    modport master (
        output start, gates_i,
        input  a_o, b_o, busy, done, pass, err_count, vec_idx
    );
    modport slave (
        input  start, gates_i,
        output a_o, b_o, busy, done, pass, err_count, vec_idx
    );
`endif
endinterface

// File: rtl/gate_vector_checker.sv
// Self-checking responder for a two-input gate bank (AND/OR/NOT/NAND/NOR/XOR/XNOR).
// Walks all four {a,b} vectors, waits SETTLE_CYC cycles, compares the seven gate
// outputs against the truth table and reports pass/fail plus an error count.
// Optional build macro GATE_CHK_LOG_EN adds first_fail_vec/first_fail_mask capture.
module gate_vector_checker #(
    parameter int         SETTLE_CYC = 2,
    parameter logic [6:0] CHK_MASK   = 7'h7F
) (
    input  logic                 clk,
    input  logic                 rst,
    gate_vector_checker_if.slave bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRIVE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);

    logic [2:0] state;
    logic [3:0] settle_cnt;
    logic       a_q;
    logic       b_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [2:0] err_q;
    logic [1:0] idx_q;
    logic [6:0] expected_gates;
    logic [6:0] diff;
    logic       mismatch;

    // Truth-table row for the vector currently applied to the gate bank
    always_comb begin
        expected_gates = 7'h1D;
        case (idx_q)
            2'd1:    expected_gates = 7'h3A;
            2'd2:    expected_gates = 7'h2A;
            2'd3:    expected_gates = 7'h61;
            default: expected_gates = 7'h1D;
        endcase
    end

    assign diff     = (bus.gates_i ^ expected_gates) & CHK_MASK;
    assign mismatch = |diff;

    // Run sequencer: drive a vector, let it settle, check it, then report
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= 4'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= 3'd0;
            idx_q      <= 2'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        err_q  <= 3'd0;
                        pass_q <= 1'b0;
                        idx_q  <= 2'd0;
                        state  <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    a_q        <= idx_q[1];
                    b_q        <= idx_q[0];
                    settle_cnt <= SETTLE_LOAD;
                    busy_q     <= 1'b1;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt <= 4'd1) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        err_q <= err_q + 3'd1;
                    end
                    if (idx_q == 2'd3) begin
                        state <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 2'd1;
                        state <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    pass_q <= (err_q == 3'd0);
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.a_o       = a_q;
    assign bus.b_o       = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.vec_idx   = idx_q;

`ifdef GATE_CHK_LOG_EN
    logic [1:0] ff_vec_q;
    logic [6:0] ff_mask_q;

    // Keep the first failing vector of a run; err_q==0 means none logged yet
    always_ff @(posedge clk) begin
        if (rst) begin
            ff_vec_q  <= 2'd0;
            ff_mask_q <= 7'd0;
        end else if (state == ST_IDLE && bus.start) begin
            ff_vec_q  <= 2'd0;
            ff_mask_q <= 7'd0;
        end else if (state == ST_CHECK && mismatch && err_q == 3'd0) begin
            ff_vec_q  <= idx_q;
            ff_mask_q <= diff;
        end
    end

    assign bus.first_fail_vec  = ff_vec_q;
    assign bus.first_fail_mask = ff_mask_q;
`endif

endmodule
